mul_functional_unit: RTL and testbench

//  Multi-cycle RV32M multiply unit; the consumer of the issue stream from the MUL reservation table.

---
 rtl/mul_functional_unit.sv | 164 ++++++++++++++++
 tb/tb_mul_functional_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_functional_unit.sv
// Multi-cycle RV32M multiply unit (MUL/MULH/MULHSU/MULHU). It handles one instruction at a time
// and holds the result on the CDB until the CDB grant (cdb_ack) arrives.
module mul_functional_unit #(
    parameter int XLEN        = 32,
    parameter int ROB_ID_W    = 3,
    parameter int PREG_W      = 6,
    parameter int MUL_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                start_calculate,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     rs1_v,
    input  logic [XLEN-1:0]     rs2_v,
    input  logic [ROB_ID_W-1:0] rob_id,
    input  logic [PREG_W-1:0]   pd,
    input  logic [4:0]          rd,
    output logic                fu_ready,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [PREG_W-1:0]   cdb_pd,
    output logic [4:0]          cdb_rd,
    output logic [XLEN-1:0]     cdb_data,
    input  logic                cdb_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int             CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic           SINGLE   = (MUL_LATENCY == 1);

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_count;
    logic [1:0]          r_op;
    logic [XLEN-1:0]     r_rs1;
    logic [XLEN-1:0]     r_rs2;
    logic [ROB_ID_W-1:0] r_rob_id;
    logic [PREG_W-1:0]   r_pd;
    logic [4:0]          r_rd;
    logic                r_cdb_valid;
    logic [ROB_ID_W-1:0] r_cdb_rob_id;
    logic [PREG_W-1:0]   r_cdb_pd;
    logic [4:0]          r_cdb_rd;
    logic [XLEN-1:0]     r_cdb_data;

    logic                w_idle;
    logic                w_accept;
    logic                w_finish;
    logic [1:0]          w_src_op;
    logic [XLEN-1:0]     w_src_rs1;
    logic [XLEN-1:0]     w_src_rs2;
    logic [ROB_ID_W-1:0] w_src_rob_id;
    logic [PREG_W-1:0]   w_src_pd;
    logic [4:0]          w_src_rd;
    logic [XLEN-1:0]     w_result;

    // Both operands are extended to 2*XLEN+2 bits. The low bits of a modular product then equal
    // the low bits of the signed product of the (XLEN+1)-bit operands {s, x}.
    function automatic logic [XLEN-1:0] mul_result(input logic [1:0]      op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic              s1;
        logic              s2;
        logic [2*XLEN+1:0] ext_a;
        logic [2*XLEN+1:0] ext_b;
        logic [2*XLEN+1:0] prod;
        s1    = (op != 2'b11) & a[XLEN-1];
        s2    = (op[1] == 1'b0) & b[XLEN-1];
        ext_a = {{(XLEN+2){s1}}, a};
        ext_b = {{(XLEN+2){s2}}, b};
        prod  = ext_a * ext_b;
        if (op == 2'b00) begin
            return prod[XLEN-1:0];
        end
        return prod[2*XLEN-1:XLEN];
    endfunction

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && start_calculate;
    assign w_finish = (w_accept && SINGLE) || ((r_state == ST_BUSY) && (r_count == CNT_ONE));

    // A single-cycle build completes in the accept cycle, so it multiplies the live inputs.
    assign w_src_op     = w_idle ? funct3[1:0] : r_op;
    assign w_src_rs1    = w_idle ? rs1_v       : r_rs1;
    assign w_src_rs2    = w_idle ? rs2_v       : r_rs2;
    assign w_src_rob_id = w_idle ? rob_id      : r_rob_id;
    assign w_src_pd     = w_idle ? pd          : r_pd;
    assign w_src_rd     = w_idle ? rd          : r_rd;
    assign w_result     = mul_result(w_src_op, w_src_rs1, w_src_rs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_op         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rob_id     <= '0;
            r_pd         <= '0;
            r_rd         <= '0;
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_id <= '0;
            r_cdb_pd     <= '0;
            r_cdb_rd     <= '0;
            r_cdb_data   <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_cdb_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_calculate) begin
                        r_op     <= funct3[1:0];
                        r_rs1    <= rs1_v;
                        r_rs2    <= rs2_v;
                        r_rob_id <= rob_id;
                        r_pd     <= pd;
                        r_rd     <= rd;
                        r_count  <= CNT_INIT;
                        r_state  <= SINGLE ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_count <= r_count - CNT_ONE;
                    if (r_count == CNT_ONE) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (cdb_ack) begin
                        r_state     <= ST_IDLE;
                        r_cdb_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_finish) begin
                r_cdb_valid  <= 1'b1;
                r_cdb_data   <= w_result;
                r_cdb_rob_id <= w_src_rob_id;
                r_cdb_pd     <= w_src_pd;
                r_cdb_rd     <= w_src_rd;
            end
        end
    end

    assign fu_ready   = w_idle;
    assign cdb_valid  = r_cdb_valid;
    assign cdb_rob_id = r_cdb_rob_id;
    assign cdb_pd     = r_cdb_pd;
    assign cdb_rd     = r_cdb_rd;
    assign cdb_data   = r_cdb_data;

    // An issue strobe that arrives while the unit is not idle must leave the captured instruction untouched.
    a_busy_start_ignored: assert property (@(posedge clk) disable iff (rst)
        (start_calculate && !fu_ready) |=> ($stable(r_rs1) && $stable(r_rs2) && $stable(r_rob_id)));

endmodule

// File: tb/tb_mul_functional_unit.sv
// Scoreboarded bench for mul_functional_unit. The driver pushes reference results, and a
// negedge monitor pops and compares them against the CDB.
module tb_mul_functional_unit;
    localparam int LAT = 4;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  rob;
        logic [5:0]  pd;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, start_calculate, cdb_ack, s1_start, s1_ack;
    logic [2:0]  funct3;
    logic [31:0] rs1_v, rs2_v;
    logic [2:0]  rob_id;
    logic [5:0]  pd;
    logic [4:0]  rd;
    logic        fu_ready, cdb_valid, fu_ready1, cdb_valid1;
    logic [2:0]  cdb_rob_id, cdb_rob_id1;
    logic [5:0]  cdb_pd, cdb_pd1;
    logic [4:0]  cdb_rd, cdb_rd1;
    logic [31:0] cdb_data, cdb_data1;

    mul_functional_unit #(.XLEN(32), .ROB_ID_W(3), .PREG_W(6), .MUL_LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .start_calculate(start_calculate),
        .funct3(funct3), .rs1_v(rs1_v), .rs2_v(rs2_v), .rob_id(rob_id), .pd(pd), .rd(rd),
        .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_pd(cdb_pd),
        .cdb_rd(cdb_rd), .cdb_data(cdb_data), .cdb_ack(cdb_ack)
    );

    mul_functional_unit #(.XLEN(32), .ROB_ID_W(3), .PREG_W(6), .MUL_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .start_calculate(s1_start),
        .funct3(funct3), .rs1_v(rs1_v), .rs2_v(rs2_v), .rob_id(rob_id), .pd(pd), .rd(rd),
        .fu_ready(fu_ready1), .cdb_valid(cdb_valid1), .cdb_rob_id(cdb_rob_id1), .cdb_pd(cdb_pd1),
        .cdb_rd(cdb_rd1), .cdb_data(cdb_data1), .cdb_ack(s1_ack)
    );

    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    bit   chk_en = 0;
    bit   m_ready = 0;
    bit   m_ready_nx = 1;
    int   m_due = 0;
    exp_t exp_q[$];

    // Staged inputs; tick() applies them just after the next rising edge
    logic        d_start, d_flush, d_rst, d_ack, d_s1;
    logic [2:0]  d_f3;
    logic [31:0] d_a, d_b;
    logic [2:0]  d_rob;
    logic [5:0]  d_pd;
    logic [4:0]  d_rd;

    logic [2:0]  sg_f3  [4] = '{3'd1, 3'd3, 3'd2, 3'd0};
    logic [31:0] sg_a   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] sg_b   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0002};
    logic [31:0] sg_exp [4] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: exact 64-bit products picked by signedness, then the requested half.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            2'd0:    p = 64'(ua * ub);
            2'd1:    p = 64'(sa * sb);
            2'd2:    p = 64'(sa * ub);
            default: p = 64'(ua * ub);
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        d_start = 1'b1;
        d_f3    = f3;
        d_a     = a;
        d_b     = b;
        d_rob   = 3'($urandom());
        d_pd    = 6'($urandom());
        d_rd    = 5'($urandom());
    endtask

    // Advance one cycle: apply the staged inputs and predict the unit's state for the next cycle.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        m_ready         = m_ready_nx;
        start_calculate = d_start;
        flush           = d_flush;
        rst             = d_rst;
        cdb_ack         = d_ack;
        s1_start        = d_s1;
        funct3          = d_f3;
        rs1_v           = d_a;
        rs2_v           = d_b;
        rob_id          = d_rob;
        pd              = d_pd;
        rd              = d_rd;
        if (d_rst || d_flush) begin
            if (!m_ready && exp_q.size() != 0 && exp_q[0].due > cyc) exp_q.delete();
            m_ready_nx = 1'b1;
        end else if (m_ready && d_start) begin
            e.data = ref_mul(d_f3[1:0], d_a, d_b);
            e.rob  = d_rob;
            e.pd   = d_pd;
            e.rd   = d_rd;
            e.due  = cyc + LAT;
            exp_q.push_back(e);
            m_due      = cyc + LAT;
            m_ready_nx = 1'b0;
        end else if (!m_ready && cyc >= m_due && d_ack) begin
            m_ready_nx = 1'b1;
        end
        d_start = 1'b0;
        d_flush = 1'b0;
        d_s1    = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: checks handshake against the model every cycle and pops the scoreboard on each broadcast.
    exp_t cur;
    bit   holding = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("fu_ready", 64'(fu_ready), 64'(m_ready));
            chk("cdb_valid", 64'(cdb_valid), 64'(!m_ready && cyc >= m_due));
            if (cdb_valid === 1'b1) begin
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_broadcast: got rob=%0d data=0x%08h, expected no result (cycle %0d)",
                                 cdb_rob_id, cdb_data, cyc);
                    end else begin
                        cur     = exp_q.pop_front();
                        holding = 1;
                        chk("cdb_latency", 64'(cyc), 64'(cur.due));
                        $display("cycle %0d: result rob=%0d pd=%0d rd=%0d data=0x%08h",
                                 cyc, cdb_rob_id, cdb_pd, cdb_rd, cdb_data);
                    end
                end
                if (holding) begin
                    chk("cdb_data", 64'(cdb_data), 64'(cur.data));
                    chk("cdb_rob_id", 64'(cdb_rob_id), 64'(cur.rob));
                    chk("cdb_pd", 64'(cdb_pd), 64'(cur.pd));
                    chk("cdb_rd", 64'(cdb_rd), 64'(cur.rd));
                end
                if (cdb_ack || flush || rst) holding = 0;
            end else begin
                holding = 0;
            end
        end
    end

    initial begin
        logic [31:0] bp_exp;
        logic [2:0]  bp_rob;
        logic [31:0] e1;
        rst = 1'b1; flush = 1'b0; start_calculate = 1'b0; cdb_ack = 1'b0; s1_start = 1'b0; s1_ack = 1'b1;
        funct3 = '0; rs1_v = '0; rs2_v = '0; rob_id = '0; pd = '0; rd = '0;
        d_start = 1'b0; d_flush = 1'b0; d_rst = 1'b1; d_ack = 1'b0; d_s1 = 1'b0;
        d_f3 = '0; d_a = '0; d_b = '0; d_rob = '0; d_pd = '0; d_rd = '0;

        run(3);
        d_rst = 1'b0;
        tick();
        chk_en = 1;
        @(negedge clk);
        chk("reset_fu_ready", 64'(fu_ready), 64'd1);
        chk("reset_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("reset_cdb_data", 64'(cdb_data), 64'd0);
        chk("reset_cdb_rob_id", 64'(cdb_rob_id), 64'd0);
        chk("reset_cdb_pd", 64'(cdb_pd), 64'd0);
        chk("reset_cdb_rd", 64'(cdb_rd), 64'd0);
        chk("reset_l1_fu_ready", 64'(fu_ready1), 64'd1);

        // MUL 7*6 with rob 3, pd 12
        issue(3'd0, 32'd7, 32'd6);
        d_rob = 3'd3; d_pd = 6'd12;
        tick();
        run(3);
        @(negedge clk);
        chk("mul7x6_not_early", 64'(cdb_valid), 64'd0);
        d_ack = 1'b1;
        tick();
        @(negedge clk);
        chk("mul7x6_valid", 64'(cdb_valid), 64'd1);
        chk("mul7x6_data", 64'(cdb_data), 64'h2A);
        chk("mul7x6_rob", 64'(cdb_rob_id), 64'd3);
        chk("mul7x6_pd", 64'(cdb_pd), 64'd12);
        d_ack = 1'b0;
        tick();
        @(negedge clk);
        chk("mul7x6_ready_after_ack", 64'(fu_ready), 64'd1);

        // Signedness corner cases, ack held high so each result is consumed immediately
        d_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(sg_f3[i], sg_a[i], sg_b[i]);
            tick();
            run(LAT);
            @(negedge clk);
            chk("signed_case_data", 64'(cdb_data), 64'(sg_exp[i]));
            tick();
        end

        // Back-pressure: result held for 5 extra cycles; a start in the middle must be ignored
        d_ack = 1'b0;
        issue(3'd2, 32'h8000_0001, 32'h0001_2345);
        bp_exp = ref_mul(2'd2, 32'h8000_0001, 32'h0001_2345);
        bp_rob = d_rob;
        tick();
        run(LAT);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) issue(3'd0, 32'd3, 32'd9);
            tick();
            @(negedge clk);
            chk("bp_valid", 64'(cdb_valid), 64'd1);
            chk("bp_fu_ready", 64'(fu_ready), 64'd0);
            chk("bp_data", 64'(cdb_data), 64'(bp_exp));
            chk("bp_rob", 64'(cdb_rob_id), 64'(bp_rob));
        end
        d_ack = 1'b1;
        tick();
        d_ack = 1'b0;
        tick();

        // Flush two cycles after issue, restart the following cycle
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        tick();
        tick();
        d_flush = 1'b1;
        tick();
        issue(3'd1, 32'hFFFF_FFF0, 32'h0000_0100);
        tick();
        @(negedge clk);
        chk("flush_ready_t3", 64'(fu_ready), 64'd1);
        d_ack = 1'b1;
        run(3);
        @(negedge clk);
        chk("flush_new_not_early", 64'(cdb_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("flush_new_valid_t7", 64'(cdb_valid), 64'd1);
        chk("flush_new_data", 64'(cdb_data), 64'(ref_mul(2'd1, 32'hFFFF_FFF0, 32'h0000_0100)));
        tick();

        // Flush together with start while idle: nothing accepted
        d_flush = 1'b1;
        issue(3'd0, 32'd5, 32'd5);
        tick();
        tick();
        @(negedge clk);
        chk("flush_start_ready", 64'(fu_ready), 64'd1);
        chk("flush_start_no_valid", 64'(cdb_valid), 64'd0);
        run(LAT + 1);

        // Reset while holding a result
        d_ack = 1'b0;
        issue(3'd0, 32'd3, 32'd5);
        d_rob = 3'd6; d_pd = 6'd33; d_rd = 5'd17;
        tick();
        run(LAT);
        d_rst = 1'b1;
        tick();
        d_rst = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_done_valid", 64'(cdb_valid), 64'd0);
        chk("rst_done_data", 64'(cdb_data), 64'd0);
        chk("rst_done_rob", 64'(cdb_rob_id), 64'd0);
        chk("rst_done_pd", 64'(cdb_pd), 64'd0);
        chk("rst_done_rd", 64'(cdb_rd), 64'd0);

        // Single-cycle build: result visible one cycle after the start
        for (int i = 0; i < 3; i++) begin
            d_f3 = 3'($urandom()); d_a = rand_opnd(); d_b = rand_opnd();
            d_rob = 3'($urandom()); d_pd = 6'($urandom()); d_rd = 5'($urandom());
            e1 = ref_mul(d_f3[1:0], d_a, d_b);
            d_s1 = 1'b1;
            tick();
            @(negedge clk);
            chk("l1_not_yet_valid", 64'(cdb_valid1), 64'd0);
            tick();
            @(negedge clk);
            chk("l1_valid_t1", 64'(cdb_valid1), 64'd1);
            chk("l1_data", 64'(cdb_data1), 64'(e1));
            chk("l1_rob", 64'(cdb_rob_id1), 64'(d_rob));
            chk("l1_busy", 64'(fu_ready1), 64'd0);
            tick();
            @(negedge clk);
            chk("l1_ready_after_ack", 64'(fu_ready1), 64'd1);
        end

        // Random traffic: random ops, back-pressure, flushes, resets and ignored starts
        for (int i = 0; i < 3000; i++) begin
            d_ack = ($urandom_range(0, 2) != 0);
            d_rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) d_flush = 1'b1;
            if ($urandom_range(0, 1) == 1) issue(3'($urandom()), rand_opnd(), rand_opnd());
            tick();
        end
        d_rst = 1'b0;
        d_ack = 1'b1;
        run(LAT + 3);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
